uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single transmitter of the `uart` block between `NUM_REQ` on-chip requesters. Each requester hands over bytes through a valid/ready handshake. The arbiter sequences the UART's `tx_en`/`tx_busy` protocol for each byte. A requester keeps ownership for a multi-byte message until it flags the last byte. Arbitration between messages is round-robin, and a timeout guards against a stalled UART or a stalled owner.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1024: cycles allowed in LOAD (waiting for `tx_busy` to rise) or HOLD (waiting for the owner's next byte) before abort. Must be at least 2.
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on `req_data[8*i+7:8*i]`.
- `req_data`  in  8*NUM_REQ  packed bytes.
- `req_last`  in  NUM_REQ  the byte offered is the last of its message.
- `req_ready`  out  NUM_REQ  one-hot. The byte is taken in the cycle where `req_valid[i]` and `req_ready[i]` are both 1.
- `uart_tx_en`  out  1  to `uart.tx_en`.
- `uart_tx_data`  out  8  to `uart.tx_data`; registered.
- `uart_tx_busy`  in  1  from `uart.tx_busy`.
- `grant_id`  out  $clog2(NUM_REQ)  current or most recent owner.
- `arb_active`  out  1  state is not IDLE.
- `err_timeout`  out  1  one-cycle pulse on abort.

## Operation
- States:
  - IDLE: no owner.
  - LOAD: byte captured; `uart_tx_en` = 1.
  - SEND: UART is shifting the byte.
  - HOLD: owner is locked and its next byte is awaited.
- IDLE:
  - Arbitration happens only when `uart_tx_busy` = 0. This covers a UART still busy after a reset.
  - The winner is the first `i` with `req_valid[i]` = 1, searching from `rr_ptr` upward with wrap at `NUM_REQ`.
  - `req_ready[winner]` = 1 combinationally.
  - Registered at capture: byte into `uart_tx_data`, winner into `grant_id`, `req_last[winner]` into `last_q`.
  - Next state is LOAD.
- LOAD:
  - `uart_tx_en` = 1 and `uart_tx_data` is held.
  - When `uart_tx_busy` is sampled 1, go to SEND; `uart_tx_en` is 0 from the next cycle.
  - On timeout, go to IDLE.
- SEND:
  - Wait for `uart_tx_busy` sampled 0.
  - If `last_q` = 1, go to IDLE and set `rr_ptr` to `(grant_id+1) mod NUM_REQ`.
  - Otherwise go to HOLD.
- HOLD:
  - Only `req_valid[grant_id]` is considered. When it is 1, `req_ready[grant_id]` = 1, the byte and `last_q` are captured, and the next state is LOAD.
  - Other requesters stall even if they are valid.
  - On timeout, go to IDLE.
- Timeout:
  - A counter clears on every state entry and increments in LOAD and HOLD.
  - When it reaches `TIMEOUT-1`:
    - go to IDLE and drop `uart_tx_en`;
    - pulse `err_timeout`;
    - advance `rr_ptr` past the owner.
  - The byte in LOAD is discarded, not retried.
- `req_ready` is 0 in LOAD and SEND and for all non-owners.
- Reset sets:
  - state to IDLE;
  - `rr_ptr`, `grant_id` and `uart_tx_data` to 0;
  - `uart_tx_en`, `req_ready`, `arb_active` and `err_timeout` to 0;
  - the counter to 0.

  Reset mid-message drops the lock with no error pulse.

## Timing
- Capture happens in cycle C (IDLE or HOLD, `req_ready` high).
  - `uart_tx_en` is 1 from C+1.
  - `uart_tx_en` falls one cycle after `uart_tx_busy` is first sampled 1.
- Back-to-back within a message: the next capture can occur in the cycle after `uart_tx_busy` is sampled 0, via HOLD.
  - Minimum HOLD→capture latency is 0 cycles: HOLD is entered and can capture combinationally in the same cycle it is entered.
- Between messages: IDLE lasts at least 1 cycle before the new capture.
- A `req_valid` rising in the same cycle as a message ends is seen in the following IDLE cycle. The new `rr_ptr` applies there.
- `req_last` is sampled only in the capture cycle.
- `req_data` may change after capture.

## Structure
- Package `uart_arb_pkg`: state enum (IDLE, LOAD, SEND, HOLD) and localparam `PTR_W = $clog2(NUM_REQ)` helper.
- Sub-module `rr_pick`: combinational round-robin search. Inputs are `req` and `ptr`; outputs are `gnt_id` and `any`.
- The arbiter contains the FSM, timeout counter, and output registers.

## Test plan
- Single byte: requester 2 offers 0x41 with last=1.
  - `req_ready[2]` pulses once.
  - `uart_tx_data` = 0x41 and `uart_tx_en` rises the next cycle and falls after busy.
  - `rr_ptr` becomes 3.
- Message lock: requester 0 sends 0x10, 0x11, 0x12 (last on 0x12) while requester 1 is continuously valid.
  - All three bytes go out before any `req_ready[1]`.
  - Requester 1's byte follows.
- Fairness: all 4 requesters are continuously valid with single-byte messages. Grants go 0, 1, 2, 3, 0, with no requester granted twice in a row.
- UART stall: `uart_tx_busy` is held 0 for `TIMEOUT` = 1024 cycles after capture.
  - `err_timeout` pulses exactly once and `uart_tx_en` drops.
  - The state returns to IDLE and the next requester is granted.
- Owner stall: requester 1 sends 0x20 with last=0, then goes silent.
  - After 1024 HOLD cycles, `err_timeout` pulses and requester 2 (valid) is granted.
- Reset during SEND with the UART still busy:
  - All outputs are 0 after reset.
  - No `req_ready` is issued until `uart_tx_busy` returns to 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and
// pointer-width helper used to size requester indices.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_e;

  function automatic int ptr_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int PTR_W           = ptr_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first asserted req at or above ptr,
// wrapping at N.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEFAULT,
  parameter int W = ptr_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  logic [W-1:0] idx_s;

  // Scan from farthest to nearest so the nearest requester at or after ptr wins
  always_comb begin
    gnt_id = '0;
    idx_s  = '0;
    any    = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s  = W'((int'(ptr) + k) % N);
      gnt_id = req[idx_s] ? idx_s : gnt_id;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ requesters with per-message
// ownership, round-robin arbitration and a LOAD/HOLD stall timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx_en,
  output logic [7:0]                 uart_tx_data,
  input  logic                       uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_active,
  output logic                       err_timeout
);

  localparam int               IDW     = ptr_width(NUM_REQ);
  localparam int               CNT_W   = ptr_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [IDW-1:0]   rr_ptr_r, ptr_s, pick_id_s, cap_id_s, rr_next_s;
  logic             pick_any_s, cap_s, timeout_s, last_r;

  rr_pick #(.N(NUM_REQ), .W(IDW)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_r),
    .gnt_id (pick_id_s),
    .any    (pick_any_s)
  );

  assign rr_next_s = (grant_id == IDW'(NUM_REQ - 1)) ? IDW'(0) : grant_id + IDW'(1);

  // Next-state, capture handshake and timeout decision
  always_comb begin
    state_s   = state_r;
    ptr_s     = rr_ptr_r;
    cap_s     = 1'b0;
    cap_id_s  = grant_id;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s && !uart_tx_busy) begin
          cap_s    = 1'b1;
          cap_id_s = pick_id_s;
          state_s  = ST_LOAD;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (uart_tx_busy) begin
          state_s = ST_SEND;
        end else if (cnt_r == CNT_MAX) begin
          timeout_s = 1'b1;
          ptr_s     = rr_next_s;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (uart_tx_busy) begin
          state_s = ST_SEND;
        end else if (last_r) begin
          ptr_s   = rr_next_s;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A byte offered on the final HOLD cycle still wins over the abort
        if (req_valid[grant_id]) begin
          cap_s   = 1'b1;
          state_s = ST_LOAD;
        end else if (cnt_r == CNT_MAX) begin
          timeout_s = 1'b1;
          ptr_s     = rr_next_s;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Stall counter: restarts on every state entry, runs only while waiting
  always_comb begin
    cnt_s = '0;
    if (state_s != state_r) begin
      cnt_s = '0;
    end else if ((state_r == ST_LOAD) || (state_r == ST_HOLD)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = '0;
    end
  end

  // One-hot ready towards the requester being captured this cycle
  always_comb begin
    req_ready = '0;
    if (cap_s && rst_n) begin
      req_ready = NUM_REQ'(1) << cap_id_s;
    end else begin
      req_ready = '0;
    end
  end

  // State, stall counter and round-robin pointer
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rr_ptr_r <= ptr_s;
    end
  end

  // Captured byte, owner and registered status outputs
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      grant_id     <= '0;
      uart_tx_data <= 8'h00;
      last_r       <= 1'b0;
      uart_tx_en   <= 1'b0;
      arb_active   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (cap_s) begin
        grant_id     <= cap_id_s;
        uart_tx_data <= req_data[{cap_id_s, 3'b000} +: 8];
        last_r       <= req_last[cap_id_s];
      end
      uart_tx_en  <= (state_s == ST_LOAD);
      arb_active  <= (state_s != ST_IDLE);
      err_timeout <= timeout_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: expected (owner, byte) pairs are queued at stimulus time
// and popped by a monitor each time uart_tx_en rises.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int TO   = 1024;
  localparam int BLEN = 4;

  logic            sys_clk = 1'b0;
  logic            rst_n   = 1'b0;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic            uart_tx_en, uart_tx_busy, arb_active, err_timeout;
  logic [7:0]      uart_tx_data;
  logic [1:0]      grant_id;

  logic model_busy = 1'b0;
  logic force_on   = 1'b0;
  logic force_val  = 1'b0;
  assign uart_tx_busy = force_on ? force_val : model_busy;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .arb_active   (arb_active),
    .err_timeout  (err_timeout)
  );

  int         errors = 0;
  int         checks = 0;
  logic [9:0] exp_q[$];
  logic [8:0] rq[NR][$];
  int         rd_idx[NR];
  int         hs_cnt[NR];
  int         fire_cyc[NR];
  int         cyc = 0, err_cnt = 0, err_cyc = 0;
  logic [NR-1:0] drv_f, fire_p = '0;
  logic       en_p = 1'b0, busy_p = 1'b0;
  logic [9:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_tx(input int r, input logic [7:0] d);
    exp_q.push_back({2'(r), d});
  endtask

  function automatic bit drained();
    for (int i = 0; i < NR; i++) if (rd_idx[i] < rq[i].size()) return 1'b0;
    return (req_valid == '0);
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(drained() && !arb_active && !uart_tx_busy && exp_q.size() == 0) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk(name, int'(n < budget), 1);
  endtask

  // UART model: busy rises the cycle after tx_en is seen and lasts BLEN cycles
  initial forever begin
    @(negedge sys_clk);
    if (uart_tx_en && !model_busy) begin
      @(posedge sys_clk); #1 model_busy = 1'b1;
      repeat (BLEN) @(posedge sys_clk);
      #1 model_busy = 1'b0;
    end
  end

  // Requester driver: each requester walks its own byte queue on handshakes
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge sys_clk);
      drv_f = req_valid & req_ready;
      @(posedge sys_clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (drv_f[i]) rd_idx[i]++;
        if (rd_idx[i] < rq[i].size()) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][rd_idx[i]][7:0];
          req_last[i]        = rq[i][rd_idx[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on each tx_en rise plus protocol checks
  initial forever begin
    @(negedge sys_clk);
    cyc++;
    if (err_timeout) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (rst_n) begin
      if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 1);
      if (uart_tx_en && !en_p) begin
        chk("en_after_capture", int'(fire_p != '0), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got grant %0d data 0x%02h, required no transfer", grant_id, uart_tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_grant", int'(grant_id), int'(mon_e[9:8]));
          chk("tx_data", int'(uart_tx_data), int'(mon_e[7:0]));
        end
      end
      if (en_p && busy_p) chk("en_fall_after_busy", int'(uart_tx_en), 0);
      if (err_timeout) begin
        chk("timeout_en_low", int'(uart_tx_en), 0);
        chk("timeout_idle", int'(arb_active), 0);
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_cnt[i]++;
          fire_cyc[i] = cyc;
        end
      end
    end
    fire_p = req_valid & req_ready;
    en_p   = uart_tx_en;
    busy_p = uart_tx_busy;
  end

  initial begin
    int n, e0, h0, h1;
    tick(3);
    chk("rst_tx_en", int'(uart_tx_en), 0);
    chk("rst_tx_data", int'(uart_tx_data), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_active", int'(arb_active), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    tick(2);

    // Fairness: every requester holds two single-byte messages
    for (int r = 0; r < NR; r++) begin
      push(r, 1'b1, 8'hA0 + 8'(r));
      push(r, 1'b1, 8'hB0 + 8'(r));
    end
    for (int r = 0; r < NR; r++) expect_tx(r, 8'hA0 + 8'(r));
    for (int r = 0; r < NR; r++) expect_tx(r, 8'hB0 + 8'(r));
    wait_idle("fair_done", 400);

    // Single byte from requester 2
    h0 = hs_cnt[2];
    push(2, 1'b1, 8'h41);
    expect_tx(2, 8'h41);
    wait_idle("single_done", 100);
    chk("single_ready_pulses", hs_cnt[2] - h0, 1);
    chk("single_rr_ptr", int'(dut.rr_ptr_r), 3);

    // Message lock: requester 0 keeps the UART while requester 1 waits
    push(0, 1'b0, 8'h10);
    push(0, 1'b0, 8'h11);
    push(0, 1'b1, 8'h12);
    push(1, 1'b1, 8'h55);
    expect_tx(0, 8'h10);
    expect_tx(0, 8'h11);
    expect_tx(0, 8'h12);
    expect_tx(1, 8'h55);
    wait_idle("lock_done", 200);
    chk("lock_order", int'(fire_cyc[1] > fire_cyc[0]), 1);

    // UART stall: busy never rises after capture
    force_val = 1'b0;
    force_on  = 1'b1;
    e0 = err_cnt;
    push(2, 1'b1, 8'hC2);
    expect_tx(2, 8'hC2);
    n = 0;
    while (err_cnt == e0 && n < TO + 200) begin @(negedge sys_clk); n++; end
    chk("stall_seen", int'(n < TO + 200), 1);
    chk("stall_latency", err_cyc - fire_cyc[2], TO + 1);
    tick(10);
    chk("stall_pulses", err_cnt - e0, 1);
    force_on = 1'b0;
    push(3, 1'b1, 8'hD3);
    push(1, 1'b1, 8'hE1);
    expect_tx(3, 8'hD3);
    expect_tx(1, 8'hE1);
    wait_idle("stall_recover", 200);

    // Owner stall: requester 1 goes silent mid-message, requester 2 waits
    e0 = err_cnt;
    h1 = hs_cnt[1];
    push(1, 1'b0, 8'h20);
    expect_tx(1, 8'h20);
    n = 0;
    while (hs_cnt[1] == h1 && n < 50) begin @(negedge sys_clk); n++; end
    chk("hold_first_capture", int'(n < 50), 1);
    push(2, 1'b1, 8'h72);
    expect_tx(2, 8'h72);
    n = 0;
    while (err_cnt == e0 && n < TO + 200) begin @(negedge sys_clk); n++; end
    chk("hold_seen", int'(n < TO + 200), 1);
    chk("hold_latency", err_cyc - fire_cyc[1], 3 + BLEN + TO);
    wait_idle("hold_recover", 200);
    chk("hold_next_grant_cyc", fire_cyc[2] - err_cyc, 0);
    chk("hold_pulses", err_cnt - e0, 1);

    // Reset during SEND while the UART stays busy
    push(3, 1'b1, 8'h33);
    expect_tx(3, 8'h33);
    n = 0;
    while (!(uart_tx_busy && !uart_tx_en && arb_active) && n < 50) begin @(negedge sys_clk); n++; end
    chk("send_reached", int'(n < 50), 1);
    force_val = 1'b1;
    force_on  = 1'b1;
    e0 = err_cnt;
    push(0, 1'b1, 8'h44);
    expect_tx(0, 8'h44);
    rst_n = 1'b0;
    tick(2);
    chk("rst2_tx_en", int'(uart_tx_en), 0);
    chk("rst2_tx_data", int'(uart_tx_data), 0);
    chk("rst2_grant", int'(grant_id), 0);
    chk("rst2_active", int'(arb_active), 0);
    chk("rst2_err", int'(err_timeout), 0);
    chk("rst2_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("ready_while_busy", int'(req_ready), 0);
    end
    chk("rst2_no_err_pulse", err_cnt - e0, 0);
    @(posedge sys_clk); #1;
    force_on = 1'b0;
    wait_idle("rst2_recover", 100);
    chk("rst2_req0_served", hs_cnt[0] > 0 ? int'(fire_cyc[0] > err_cyc) : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
